// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the two-port memory arbiter: port count, port
//   index constants and the arbiter FSM state encoding.
package mem_arb_pkg;

    localparam int   NUM_PORTS = 2;

    // Port index constants
    localparam logic P_ICACHE  = 1'b0;
    localparam logic P_DCACHE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY0   = 2'd1,
        BUSY1   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // BUSY state that corresponds to a granted port
    function automatic arb_state_e busy_state(input logic port);
        return port ? BUSY1 : BUSY0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection between the I-cache (req0) and the
//   D-cache (req1).
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : on a tie the port that did not win last time is picked.
//     undefined : fixed priority, D-cache wins every tie.
// Ports
//   req0_i        in   I-cache request
//   req1_i        in   D-cache request
//   last_grant_i  in   port granted most recently (round-robin only)
//   grant_o       out  winning port index
//   grant_valid_o out  at least one port is requesting
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic grant_valid_o
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid_o = req0_i | req1_i;
        if (req0_i && req1_i)
            grant_o = ~last_grant_i;
        else
            grant_o = req1_i ? P_DCACHE : P_ICACHE;
    end
`else
    // History is irrelevant under fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_o       = req1_i ? P_DCACHE : P_ICACHE;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one line-wide data-memory port between the I-cache (port 0) and
//   the D-cache (port 1). The winning request is captured into registers
//   that drive the memory; completion is returned as a registered one-cycle
//   ack with the read line.
//   Optional feature macro: ARB_ROUND_ROBIN_EN (see mem_arb_pick).
// Ports
//   clk_i, rst_i                    clock, async active-low reset
//   m0_enable_i/write_i/addr_i/data_i  I-cache request
//   m0_ack_o, m0_data_o             I-cache completion pulse + read line
//   m1_*                            same for the D-cache
//   mem_enable_o/write_o/addr_o/data_o  registered memory request
//   mem_data_i, mem_ack_i           memory read line + completion pulse
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_e                        state;
    logic                              last_grant;
    logic                              grant;
    logic                              grant_valid;
    logic [NUM_PORTS-1:0]              ack_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_q;

    // Request fields of the current winner
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              busy_port;

    mem_arb_pick u_pick (
        .req0_i        (m0_enable_i),
        .req1_i        (m1_enable_i),
        .last_grant_i  (last_grant),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        sel_write = (grant == P_DCACHE) ? m1_write_i : m0_write_i;
        sel_addr  = (grant == P_DCACHE) ? m1_addr_i  : m0_addr_i;
        sel_data  = (grant == P_DCACHE) ? m1_data_i  : m0_data_i;
        busy_port = (state == BUSY1) ? P_DCACHE : P_ICACHE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            last_grant   <= P_DCACHE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= sel_write;
                        mem_addr_o   <= sel_addr;
                        mem_data_o   <= sel_data;
                        last_grant   <= grant;
                        state        <= busy_state(grant);
                    end
                end
                BUSY0, BUSY1: begin
                    // Completes even if the requester has dropped enable.
                    if (mem_ack_i) begin
                        mem_enable_o       <= 1'b0;
                        mem_write_o        <= 1'b0;
                        ack_q[busy_port]   <= 1'b1;
                        rdata_q[busy_port] <= mem_data_i;
                        state              <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Acked requester still shows enable this cycle, so no
                    // arbitration here.
                    ack_q <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_ack_o  = ack_q[P_ICACHE];
    assign m1_ack_o  = ack_q[P_DCACHE];
    assign m0_data_o = rdata_q[P_ICACHE];
    assign m1_data_o = rdata_q[P_DCACHE];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter; the bench plays both cache
//   requesters and the memory. Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_2000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          m0_enable_i = 1'b0, m0_write_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic [DW-1:0] m0_data_i = '0;
    logic          m0_ack_o;
    logic [DW-1:0] m0_data_o;
    logic          m1_enable_i = 1'b0, m1_write_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_data_i = '0;
    logic          m1_ack_o;
    logic [DW-1:0] m1_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          mem_ack_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic lg = 1'b1;   // bench copy of last grant
    logic w;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mem_ack(input logic [DW-1:0] d);
        mem_data_i = d;
        mem_ack_i  = 1'b1;
        tick();
        mem_ack_i  = 1'b0;
    endtask

    function automatic logic tie_winner(input logic last);
`ifdef ARB_ROUND_ROBIN_EN
        return ~last;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [DW-1:0] ack_of(input logic p, input logic a0, input logic a1);
        return p ? DW'(a1) : DW'(a0);
    endfunction

    initial begin
        // ---- reset
        tick(); tick();
        chk("rst_enable", DW'(mem_enable_o), '0);
        chk("rst_addr",   DW'(mem_addr_o), '0);
        chk("rst_acks",   DW'({m1_ack_o, m0_ack_o}), '0);
        chk("rst_m0_data", m0_data_o, '0);
        rst_i = 1'b1;
        tick();

        // ---- 1: port 0 read of 0x400, memory answers 3 cycles later
        m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400;
        tick();
        lg = 1'b0;
        chk("t1_enable", DW'(mem_enable_o), DW'(1));
        chk("t1_addr",   DW'(mem_addr_o), DW'(32'h400));
        chk("t1_write",  DW'(mem_write_o), '0);
        tick(); tick();
        mem_ack({32{8'hA5}});
        chk("t1_ack0",   DW'(m0_ack_o), DW'(1));
        chk("t1_data0",  m0_data_o, {32{8'hA5}});
        chk("t1_ack1",   DW'(m1_ack_o), '0);
        chk("t1_en_off", DW'(mem_enable_o), '0);
        m0_enable_i = 1'b0;
        tick();
        chk("t1_ack0_drop", DW'(m0_ack_o), '0);
        chk("t1_data0_hold", m0_data_o, {32{8'hA5}});

        // ---- 2: port 1 write of 0x1234 to 0x820
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_0820; m1_data_i = DW'(16'h1234);
        tick();
        lg = 1'b1;
        chk("t2_write", DW'(mem_write_o), DW'(1));
        chk("t2_data",  mem_data_o, DW'(16'h1234));
        chk("t2_addr",  DW'(mem_addr_o), DW'(32'h820));
        tick();
        chk("t2_hold",  mem_data_o, DW'(16'h1234));
        mem_ack('0);
        chk("t2_ack1",   DW'(m1_ack_o), DW'(1));
        chk("t2_ack0",   DW'(m0_ack_o), '0);
        chk("t2_en_off", DW'(mem_enable_o), '0);
        chk("t2_wr_off", DW'(mem_write_o), '0);
        chk("t2_m0_keep", m0_data_o, {32{8'hA5}});
        m1_enable_i = 1'b0;
        tick();
        chk("t2_ack1_drop", DW'(m1_ack_o), '0);

        // ---- 3: ties, winner drops enable after its ack
        m0_write_i = 1'b0; m1_write_i = 1'b0; m0_addr_i = A0; m1_addr_i = A1;
        for (int r = 0; r < 2; r++) begin
            m0_enable_i = 1'b1; m1_enable_i = 1'b1;
            tick();
            w = tie_winner(lg); lg = w;
            chk("t3_first", DW'(mem_addr_o), w ? DW'(A1) : DW'(A0));
            mem_ack(DW'(r + 16));
            chk("t3_first_ack", DW'({m1_ack_o, m0_ack_o}), w ? DW'(2) : DW'(1));
            if (w) m1_enable_i = 1'b0; else m0_enable_i = 1'b0;
            tick();
            chk("t3_gap", DW'(mem_enable_o), '0);
            tick();
            lg = ~w;
            chk("t3_second", DW'(mem_addr_o), w ? DW'(A0) : DW'(A1));
            chk("t3_second_en", DW'(mem_enable_o), DW'(1));
            mem_ack(DW'(r + 32));
            chk("t3_second_ack", DW'({m1_ack_o, m0_ack_o}), w ? DW'(1) : DW'(2));
            m0_enable_i = 1'b0; m1_enable_i = 1'b0;
            tick();
        end

        // ---- 4: both held for 4 transactions
        m0_enable_i = 1'b1; m1_enable_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            w = tie_winner(lg); lg = w;
            chk("t4_grant", DW'(mem_addr_o), w ? DW'(A1) : DW'(A0));
            mem_ack(DW'(k));
            chk("t4_ack", DW'({m1_ack_o, m0_ack_o}), w ? DW'(2) : DW'(1));
            tick();
        end
        m0_enable_i = 1'b0; m1_enable_i = 1'b0;
        tick();

        // ---- 5: reset during BUSY1
        m1_enable_i = 1'b1;
        tick();
        chk("t5_busy", DW'(mem_enable_o), DW'(1));
        #2 rst_i = 1'b0;
        #1;
        chk("t5_async_en",   DW'(mem_enable_o), '0);
        chk("t5_async_addr", DW'(mem_addr_o), '0);
        chk("t5_async_d1",   m1_data_o, '0);
        chk("t5_async_d0",   m0_data_o, '0);
        m1_enable_i = 1'b0;
        tick();
        rst_i = 1'b1;
        lg = 1'b1;
        mem_ack({8{32'hDEAD_BEEF}});
        chk("t5_late_ack", DW'({m1_ack_o, m0_ack_o}), '0);
        chk("t5_late_en",  DW'(mem_enable_o), '0);

        // ---- 6: port 0 drops enable mid-BUSY, port 1 waiting
        m0_enable_i = 1'b1;
        tick();
        chk("t6_grant0", DW'(mem_addr_o), DW'(A0));
        m0_enable_i = 1'b0; m1_enable_i = 1'b1;
        tick();
        chk("t6_hold", DW'(mem_addr_o), DW'(A0));
        mem_ack({8{32'h0BAD_F00D}});
        chk("t6_ack0",  DW'(m0_ack_o), DW'(1));
        chk("t6_data0", m0_data_o, {8{32'h0BAD_F00D}});
        chk("t6_ack1",  DW'(m1_ack_o), '0);
        tick();
        chk("t6_release_idle", DW'(mem_enable_o), '0);
        tick();
        chk("t6_grant1", DW'(mem_addr_o), DW'(A1));
        chk("t6_en1",    DW'(mem_enable_o), DW'(1));
        mem_ack(DW'(77));
        chk("t6_ack1_done", DW'(m1_ack_o), DW'(1));
        chk("t6_data1", m1_data_o, DW'(77));
        m1_enable_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
